// File: rtl/rr_reg_arbiter_pkg.sv
// rr_reg_arbiter_pkg: shared state encodings and sizing for the round-robin register arbiter
package rr_reg_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        ACK   = 2'b10
    } state_e;
endpackage

// File: rtl/rr_reg_arbiter_dffr_en.sv
// rr_reg_arbiter_dffr_en: WIDTH-bit register with async active-high reset and load enable
module rr_reg_arbiter_dffr_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);
    logic [WIDTH-1:0] data_d, data_q;
    always_comb data_d = en ? d : data_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end
    assign q     = data_q;
    assign q_bar = ~data_q;
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin grant of four writers onto one shared register,
// one IDLE -> WRITE -> ACK transaction at a time.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [ID_W-1:0]        grant_id,
    output logic                   ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_bar
);
    state_e             state_d, state_q;
    logic [N_REQ-1:0]   gnt_d, gnt_q;
    logic [ID_W-1:0]    id_d, id_q, last_d, last_q, winner;
    logic               ack_d, ack_q;

    // Scan downward so the nearest requester after last overwrites the rest; last itself ranks lowest.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] last);
        logic [ID_W-1:0] w, i;
        w = last;
        for (int k = N_REQ; k >= 1; k--) begin
            i = last + ID_W'(k);
            if (r[i]) w = i;
        end
        return w;
    endfunction

    assign winner = rr_pick(req, last_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        id_d    = id_q;
        last_d  = last_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                gnt_d   = N_REQ'(1) << winner;
                id_d    = winner;
                state_d = WRITE;
            end
            WRITE: begin
                last_d  = id_q;
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(N_REQ - 1);
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
        end
    end

    rr_reg_arbiter_dffr_en #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == WRITE),
        .d     (wdata[id_q*WIDTH +: WIDTH]),
        .q     (q),
        .q_bar (q_bar)
    );

    assign gnt      = gnt_q;
    assign grant_id = id_q;
    assign ack      = ack_q;
    assign busy     = state_q != IDLE;
endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin write arbiter for a shared WIDTH-bit state register built from D flip-flops. Four requesters compete to load the register. The block grants one requester at a time, commits that requester's data into the register and returns a one-cycle acknowledge. It sits between the requesting datapath blocks and the shared register, and is the only writer of that register.

## Interface
- WIDTH, 8, data width of the shared register and of each write port
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  4  request vector, bit i = requester i wants a write
- wdata  in  4*WIDTH  packed write data, requester i on bits [i*WIDTH +: WIDTH]
- gnt  out  4  one-hot grant, registered
- grant_id  out  2  index of the current or most recent winner
- ack  out  1  one-cycle pulse, write committed
- busy  out  1  high when state is not IDLE
- q  out  WIDTH  shared register value
- q_bar  out  WIDTH  bitwise complement of q

## Operation
- FSM states: IDLE, WRITE, ACK.
- IDLE, no req: stay in IDLE.
- IDLE, any req bit high:
  - Pick the winner by round robin, searching from last+1 mod 4 upward with wrap.
  - Next edge: gnt <= onehot(winner), grant_id <= winner, state <= WRITE.
- WRITE:
  - Next edge: q <= wdata slice of grant_id, last <= grant_id, gnt <= 0, ack <= 1, state <= ACK.
  - The write is committed once WRITE is entered. Dropping req during WRITE does not cancel it.
- ACK:
  - ack is high for exactly this cycle.
  - Next edge: ack <= 0, state <= IDLE.
- Requester rule: deassert req no later than the edge ending the ACK cycle. A req still high in IDLE is treated as a new request.
- Requests that rise and fall entirely within WRITE or ACK are never seen.
- Only one write is ever in flight. A request is never dropped while req is held.
- Worst-case wait for a held request: 3 transactions (9 cycles) before its own grant.
- q_bar is always ~q, including during reset.
- An illegal state encoding recovers to IDLE on the next edge, with gnt and ack cleared.

## Timing
- req high in IDLE during cycle t gives:
  - gnt valid during cycle t+1 (WRITE)
  - new q and ack visible during cycle t+2 (ACK)
  - IDLE again during cycle t+3
- Throughput: one write per 3 cycles under continuous contention.
- Reset forces all of the following immediately, independent of clk:
  - q = 0, q_bar = all ones
  - gnt = 0, grant_id = 0, ack = 0, busy = 0
  - state = IDLE, last = 3, so requester 0 has top priority after reset
- Reset asserted mid-WRITE aborts the write: q stays 0 and no ack is issued.
- The first edge after reset release behaves as IDLE arbitration.
- Simultaneous requests: exactly one gnt bit is high, never more.

## Structure
- Shared package holds:
  - state encodings: IDLE=2'b00, WRITE=2'b01, ACK=2'b10
  - N_REQ=4 and the ID width of 2
- Sub-module _dffr_en: WIDTH-bit register with async active-high reset and load enable, driving q and q_bar.
  - The arbiter drives the load enable high only in WRITE.
- Round-robin pick: combinational function of req and last, inside the arbiter.

## Test plan
- Reset, then req=4'b0100 with wdata2=8'hA5:
  - gnt=4'b0100 and busy=1 at t+1
  - q=8'hA5, q_bar=8'h5A, ack=1, grant_id=2 at t+2
  - busy=0 at t+3
- All four req held, each bit dropped after its own ack and re-raised:
  - grant order 0,1,2,3,0
  - ack every 3rd cycle
- After requester 1 is served, raise req=4'b1011 (held) -> grants 3, then 0, then 1.
- req0 dropped during WRITE with wdata0=8'h3C -> q=8'h3C and ack still pulses.
- Reset pulsed during WRITE with wdata1=8'hFF:
  - q=0, q_bar=8'hFF, gnt=0, no ack
  - the next single request goes to the lowest-indexed active requester
- req3 pulsed only during an ACK cycle -> no grant to 3, state returns to IDLE and stays.
